// File: rtl/gcd_host_if_if.sv
// gcd_host_if_if: the signal bundle between the GCD host-side initiator and
// its three neighbours.
//   upstream   : in_valid/in_ready/in_a/in_b      operand pairs in
//   downstream : out_valid/out_ready/out_gcd/out_err  results out
//   core       : gcd_start/gcd_data out, gcd_done/gcd_result in
//   status     : busy
// Modport master is the initiator (gcd_host_if). Modport slave is the
// environment around it: the operand source, the result sink and the core.
interface gcd_host_if_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         gcd_start;
  logic [W-1:0] gcd_data;
  logic         gcd_done;
  logic [W-1:0] gcd_result;
  logic         busy;

  modport master (
    input  in_valid, in_a, in_b, out_ready, gcd_done, gcd_result,
    output in_ready, out_valid, out_gcd, out_err, gcd_start, gcd_data, busy
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, gcd_done, gcd_result,
    input  in_ready, out_valid, out_gcd, out_err, gcd_start, gcd_data, busy
  );
endinterface

// File: rtl/gcd_host_if.sv
// gcd_host_if: initiator for the subtract-loop GCD core.
// Takes an operand pair from the upstream valid/ready channel, loads it onto
// the core's shared load bus (A with the start pulse, B the cycle after),
// waits for done and presents the result downstream until it is accepted.
// Pairs with a zero operand or equal operands never reach the core (the core
// would loop forever on a zero); their result is produced directly.
// Ports:
//   clk  clock, all state on posedge
//   rst  asynchronous active-high reset
//   bus  gcd_host_if_if.master: upstream, downstream, core and busy signals
// Build option: define GCD_HOST_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles, returning out_gcd = 0 with out_err = 1. Without it
// out_err is constant 0 and WAIT has no bound.
module gcd_host_if #(
  parameter int W              = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  gcd_host_if_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESP} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] b_q;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_gcd_q, out_gcd_d;
  logic         out_err_q, out_err_d;
  logic         gcd_start_q, gcd_start_d;
  logic [W-1:0] gcd_data_q, gcd_data_d;
  logic         accept;
  logic         degenerate;
  logic         timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("gcd_host_if: TIMEOUT_CYCLES must be at least 1");
  end

  assign accept     = (state_q == S_IDLE) && bus.in_valid;
  // Decided on the live inputs so a bypassed result is valid the next cycle.
  assign degenerate = (bus.in_a == '0) || (bus.in_b == '0) || (bus.in_a == bus.in_b);

`ifdef GCD_HOST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Held at zero outside WAIT, so it is cleared on every WAIT entry and
  // equals the number of WAIT cycles already spent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt_q <= '0;
    else if (state_q != S_WAIT) wait_cnt_q <= '0;
    else                        wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  // True in the WAIT cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_gcd_q   <= '0;
      out_err_q   <= 1'b0;
      gcd_start_q <= 1'b0;
      gcd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_gcd_q   <= out_gcd_d;
      out_err_q   <= out_err_d;
      gcd_start_q <= gcd_start_d;
      gcd_data_q  <= gcd_data_d;
    end
  end

  // A goes straight into the bus register on acceptance; only B is kept.
  always_ff @(posedge clk) begin
    if (accept) b_q <= bus.in_b;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = degenerate ? S_RESP : S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_WAIT;
      S_WAIT:   if (bus.gcd_done || timeout) state_d = S_RESP;
      S_RESP:   if (bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; the bus idles at zero.
  always_comb begin
    out_valid_d = out_valid_q;
    out_gcd_d   = out_gcd_q;
    out_err_d   = out_err_q;
    gcd_start_d = 1'b0;
    gcd_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (degenerate) begin
            out_valid_d = 1'b1;
            out_err_d   = 1'b0;
            // Either a zero operand (OR keeps the other) or two equal ones.
            out_gcd_d   = (bus.in_a == bus.in_b) ? bus.in_a : (bus.in_a | bus.in_b);
          end else begin
            gcd_start_d = 1'b1;
            gcd_data_d  = bus.in_a;
          end
        end
      end
      S_LOAD_A: gcd_data_d = b_q;
      S_WAIT: begin
        // Done has priority over a simultaneous timeout.
        if (bus.gcd_done) begin
          out_valid_d = 1'b1;
          out_gcd_d   = bus.gcd_result;
          out_err_d   = 1'b0;
        end else if (timeout) begin
          out_valid_d = 1'b1;
          out_gcd_d   = '0;
          out_err_d   = 1'b1;
        end
      end
      S_RESP: if (bus.out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_gcd   = out_gcd_q;
  assign bus.out_err   = out_err_q;
  assign bus.gcd_start = gcd_start_q;
  assign bus.gcd_data  = gcd_data_q;

endmodule

// File: tb/tb_gcd_host_if.sv
// tb_gcd_host_if: bench for gcd_host_if with a subtract-loop core model that
// holds done until the next start, directed cases and a randomized phase
// checked against a Euclid reference.
module tb_gcd_host_if;
  localparam int W = 16;

`ifdef GCD_HOST_TIMEOUT_EN
  localparam bit SHORT_CORE = 1'b1;
`else
  localparam bit SHORT_CORE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_host_if_if #(.W(W)) bus ();

  gcd_host_if #(.W(W), .TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Core model: captures A with start, B the next cycle, then subtracts.
  logic [W-1:0] ca, cb;
  logic [W-1:0] cres  = '0;
  logic         cdone = 1'b0;
  int           cph   = 0;
  bit           core_mute = 1'b0;

  assign bus.gcd_done   = cdone;
  assign bus.gcd_result = cres;

  always @(posedge clk) begin
    if (bus.gcd_start) begin
      ca    <= bus.gcd_data;
      cdone <= 1'b0;
      cph   <= 1;
    end else if (cph == 1) begin
      cb  <= bus.gcd_data;
      cph <= 2;
    end else if (cph == 2) begin
      if (ca == cb) begin
        if (!core_mute) begin
          cdone <= 1'b1;
          cres  <= ca;
          cph   <= 0;
        end
      end else if (ca > cb) ca <= ca - cb;
      else cb <= cb - ca;
    end
  end

  // Start-pulse monitor.
  int start_cnt      = 0;
  int last_start_cyc = -1;
  bit prev_start     = 1'b0;
  bit double_start   = 1'b0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_start <= bus.gcd_start;
    if (bus.gcd_start) begin
      start_cnt      <= start_cnt + 1;
      last_start_cyc <= cyc;
      if (prev_start) double_start <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!bus.out_valid && n < limit) begin
      tick();
      n++;
    end
    if (!bus.out_valid) chk("wait_out_valid", 0, 1);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("valid_drop", bus.out_valid, 0);
    chk("idle_after_hs", bus.in_ready, 1);
  endtask

  // One complete transaction from IDLE with the result held for 'hold' cycles.
  task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int  s0, n;
    bit  deg;
    deg = (a == 0) || (b == 0) || (a == b);
    chk("rand_in_ready", bus.in_ready, 1);
    s0 = start_cnt;
    drive(a, b);
    tick();
    bus.in_valid = 1'b0;
    if (deg) chk("rand_bypass_lat", bus.out_valid, 1);
    else wait_valid(2000, n);
    chk("rand_gcd", bus.out_gcd, gcd_ref(a, b));
    chk("rand_err", bus.out_err, 0);
    chk("rand_starts", start_cnt - s0, deg ? 0 : 1);
    repeat (hold) tick();
    chk("rand_hold", bus.out_gcd, gcd_ref(a, b));
    handshake();
  endtask

  initial begin
    int n, s0, hs;
    logic [W-1:0] ra, rb;
    logic [W-1:0] da [3] = '{16'd0, 16'd0, 16'd21};
    logic [W-1:0] db [3] = '{16'd0, 16'd42, 16'd21};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_gcd", bus.out_gcd, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_gcd_start", bus.gcd_start, 0);
    chk("rst_gcd_data", bus.gcd_data, 0);

    // (13,78) through the core
    s0 = start_cnt;
    drive(16'd13, 16'd78);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_start", bus.gcd_start, 1);
    chk("t1_data_a", bus.gcd_data, 13);
    chk("t1_busy", bus.busy, 1);
    chk("t1_in_ready", bus.in_ready, 0);
    tick();
    chk("t1_start_low", bus.gcd_start, 0);
    chk("t1_data_b", bus.gcd_data, 78);
    tick();
    chk("t1_data_idle", bus.gcd_data, 0);
    wait_valid(500, n);
    chk("t1_gcd", bus.out_gcd, gcd_ref(16'd13, 16'd78));
    chk("t1_err", bus.out_err, 0);
    chk("t1_one_start", start_cnt - s0, 1);
    handshake();

    // Degenerate pairs bypass the core
    for (int i = 0; i < 3; i++) begin
      s0 = start_cnt;
      drive(da[i], db[i]);
      tick();
      bus.in_valid = 1'b0;
      chk("t2_valid_n1", bus.out_valid, 1);
      chk("t2_gcd", bus.out_gcd, gcd_ref(da[i], db[i]));
      chk("t2_no_start", start_cnt - s0, 0);
      handshake();
    end

    // (48,18) with out_ready withheld for 5 cycles
    drive(16'd48, 16'd18);
    tick();
    bus.in_valid = 1'b0;
    wait_valid(500, n);
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid_held", bus.out_valid, 1);
      chk("t3_gcd_stable", bus.out_gcd, 6);
      chk("t3_in_ready_low", bus.in_ready, 0);
      tick();
    end
    chk("t3_still_resp", bus.busy, 1);
    handshake();

    // Back-to-back (35,14) then (17,5) with in_valid held high
    s0 = start_cnt;
    drive(16'd35, 16'd14);
    tick();
    drive(16'd17, 16'd5);
    wait_valid(500, n);
    chk("t4_first", bus.out_gcd, 7);
    chk("t4_no_accept", bus.in_ready, 0);
    chk("t4_one_start", start_cnt - s0, 1);
    hs = cyc;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t4_idle", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    wait_valid(500, n);
    chk("t4_second", bus.out_gcd, 1);
    chk("t4_two_starts", start_cnt - s0, 2);
    chk("t4_start_order", last_start_cyc > hs, 1);
    handshake();

    // Reset during WAIT of (100,75), then (9,6)
    drive(16'd100, 16'd75);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("t5_in_wait", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    chk("t5_out_gcd", bus.out_gcd, 0);
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_gcd_data", bus.gcd_data, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t5_no_resp", bus.out_valid, 0);
    drive(16'd9, 16'd6);
    tick();
    bus.in_valid = 1'b0;
    wait_valid(500, n);
    chk("t5_gcd", bus.out_gcd, 3);
    chk("t5_err", bus.out_err, 0);
    handshake();

`ifdef GCD_HOST_TIMEOUT_EN
    // Core never answers
    core_mute = 1'b1;
    drive(16'd100, 16'd75);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    wait_valid(100, n);
    chk("t6_latency", n, 8);
    chk("t6_err", bus.out_err, 1);
    chk("t6_gcd", bus.out_gcd, 0);
    handshake();
    core_mute = 1'b0;
`endif

    // Randomized pairs
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(1, 200));
      case ($urandom_range(0, 5))
        0: begin rb = ra; ra = '0; end
        1: rb = '0;
        2: rb = ra;
        default: begin
          if (SHORT_CORE) begin
            ra = W'($urandom_range(1, 100));
            rb = W'(ra * $urandom_range(2, 3));
          end else rb = W'($urandom_range(1, 200));
        end
      endcase
      run_pair(ra, rb, $urandom_range(0, 3));
    end

    chk("single_cycle_start", double_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time bound expired");
  end

endmodule

// File: doc/gcd_host_if.md
Name: gcd_host_if

Overview:
- Initiator side of the GCD core's operand-load / start / done interface.
- Accepts operand pairs on an upstream valid/ready channel and serialises them onto the core's shared 16-bit load bus (A first, then B).
- Waits for the core's done, then returns the result on a downstream valid/ready channel.
- Bypasses the core for degenerate operands (either operand zero, or equal operands) because the subtract-loop core never terminates on a zero operand.

Parameters:
- W, 16, operand/result width; matches the GCD datapath bus.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before abort; used only with GCD_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  high only in IDLE.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- out_gcd  out  W  result.
- out_err  out  1  result invalid (timeout); always 0 without the macro.
- gcd_start  out  1  one-cycle pulse to the core, coincident with operand A on gcd_data.
- gcd_data  out  W  core load bus.
- gcd_done  in  1  core done; level signal; core must drop it no later than the cycle after gcd_start.
- gcd_result  in  W  core result, valid while gcd_done = 1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - out_valid = 0, out_gcd = 0, out_err = 0.
  - gcd_start = 0, gcd_data = 0, busy = 0.
  - in_ready = 1 after reset deassertion.
- All outputs are registered except in_ready and busy, which decode state.
- States: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - On in_valid, latch in_a and in_b into a_q and b_q.
  - If a_q == 0 or b_q == 0: out_gcd <= a_q | b_q, go to RESP. This gives gcd(0,0) = 0 and gcd(x,0) = x.
  - Else if a_q == b_q: out_gcd <= a_q, go to RESP.
  - Else go to LOAD_A.
- LOAD_A: gcd_start = 1, gcd_data = a_q, for exactly one cycle; next state LOAD_B.
- LOAD_B: gcd_start = 0, gcd_data = b_q, for one cycle; next state WAIT.
- WAIT:
  - gcd_data = 0.
  - gcd_done is sampled every cycle.
  - On gcd_done = 1: out_gcd <= gcd_result, out_err <= 0, go to RESP.
- RESP:
  - out_valid = 1; out_gcd and out_err are held stable.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - in_ready is 0, so no new operands are accepted before the handshake completes.
- Latency, with operands accepted in cycle N:
  - Bypass: out_valid is high in cycle N+1.
  - Core path: gcd_start in N+1, B on bus in N+2, WAIT from N+3; out_valid in the cycle after gcd_done is first sampled high.
- gcd_done arriving outside WAIT is ignored.
- gcd_start is never asserted in any state other than LOAD_A, and never for more than one cycle per transaction.
- Reset asserted in any state: immediate return to reset values; the in-flight transaction is dropped with no response.
- A same-cycle out_ready and new in_valid in RESP gives no overlap: the new pair is accepted at the earliest in the following IDLE cycle.

Optional Feature:
- Macro: GCD_HOST_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with gcd_done still 0: out_gcd <= 0, out_err <= 1, go to RESP.
  - If gcd_done and the timeout occur in the same cycle, done wins (err = 0).
- Without the macro: no counter is built, out_err is tied 0, and WAIT can last indefinitely.

Test Plan (bench uses a behavioural subtract-loop core model with done held until the next start):
- in_a = 13, in_b = 78 → gcd_start pulse with gcd_data = 13, then gcd_data = 78 the next cycle; out_gcd = 13, out_err = 0; exactly one start pulse.
- Pairs (0,0), (0,42), (21,21) → out_valid one cycle after acceptance with 0, 42, 21 respectively; gcd_start never asserted.
- in_a = 48, in_b = 18 with out_ready held 0 for 5 cycles after out_valid → out_gcd = 6 stable; in_ready = 0 throughout; IDLE only after the handshake.
- Back-to-back pairs (35,14), (17,5) with in_valid held high → results 7 then 1, in order; the second start pulse occurs only after the first result has been accepted.
- rst pulsed during WAIT of (100,75) → all outputs return to reset values asynchronously; the next pair (9,6) returns 3 correctly.
- With GCD_HOST_TIMEOUT_EN and TIMEOUT_CYCLES = 8, the model never raises done → out_valid with out_err = 1 and out_gcd = 0, 8 cycles after WAIT entry.
